dino_jump_ctrl: RTL and testbench
=================================

DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 SHALL have parameter GROUND_Y, default 200: dino bottom-edge row when on ground, in half-resolution rows (v_cnt>>1).
REQ-002 SHALL have parameter MIN_Y, default 28: smallest allowed pos, equal to the sprite height.
REQ-003 SHALL have parameter JUMP_V0, default 10: initial upward speed, in rows per tick.
REQ-004 SHALL have parameter GRAVITY, default 1: speed change per tick.
REQ-005 SHALL have parameter VMAX, default 15: falling speed ceiling.
REQ-006 SHALL have parameter ANIM_TICKS, default 6: ticks per leg-animation toggle.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-009 SHALL have port tick, input, 1 bit: one-clk frame-step pulse.
REQ-010 SHALL have port start, input, 1 bit: one-clk pulse that starts or restarts the game.
REQ-011 SHALL have port jump, input, 1 bit: debounced jump button level.
REQ-012 SHALL have port game_over, input, 1 bit: collision level from the game logic.
REQ-013 SHALL have port pos, output, 9 bits: dino bottom-edge row, fed to the sprite renderer pos input.
REQ-014 SHALL have port airborne, output, 1 bit: high in RISE or FALL.
REQ-015 SHALL have port anim_frame, output, 1 bit: leg frame select.
REQ-016 SHALL have port state, output, 3 bits: current state code, for debug.

Function
REQ-017 SHALL implement states IDLE=0, RUN=1, RISE=2, FALL=3 and DEAD=4; codes 5-7 SHALL go to IDLE on the next clk.
REQ-018 SHALL hold an unsigned 5-bit vel register.
REQ-019 SHALL evaluate all arithmetic at 10-bit width before clamping, so no wrap-around can reach pos.
REQ-020 SHALL detect jump rising edges with a registered copy of jump; one edge equals one request.
REQ-021 SHALL set a one-entry jump_pend flag on a jump edge in RUN, RISE or FALL; extra edges while set SHALL be ignored.
REQ-022 SHALL clear jump_pend on consumption, and on entry to IDLE or DEAD.
REQ-023 In IDLE or DEAD, a start pulse SHALL, on the next clk, give state=RUN, pos=GROUND_Y, vel=0, anim_frame=0, anim counter=0 and jump_pend=0.
REQ-024 In RUN, a tick with jump_pend set, or with a jump edge in the same cycle, SHALL consume the request, set vel=JUMP_V0 and go to RISE, with pos unchanged that tick.
REQ-025 In RUN, a tick without a request SHALL advance the anim counter; when it reaches ANIM_TICKS-1, the counter SHALL go to 0 and anim_frame SHALL toggle.
REQ-026 anim_frame and the anim counter SHALL be held outside RUN.
REQ-027 In RISE on tick, pos SHALL become max(pos-vel, MIN_Y).
REQ-028 In RISE on tick, if vel<=GRAVITY or pos-vel<=MIN_Y, then vel SHALL become 0 and state SHALL become FALL; otherwise vel SHALL become vel-GRAVITY.
REQ-029 In FALL on tick, v'=min(vel+GRAVITY, VMAX); if pos+v'>=GROUND_Y then pos=GROUND_Y, vel=0 and state=RUN, else pos=pos+v' and vel=v'.
REQ-030 A request pending at landing SHALL be taken on the first RUN tick after landing; this is the buffered jump.
REQ-031 With no tick pulse, pos, vel and the anim state SHALL be held.
REQ-032 game_over high in RUN, RISE or FALL SHALL give state=DEAD on the next clk, with pos and anim_frame frozen, regardless of tick.
REQ-033 When game_over and start are both high in RUN, RISE or FALL, game_over SHALL win.
REQ-034 In DEAD, start SHALL restart per REQ-023 even if game_over is still high.
REQ-035 In DEAD, tick and jump SHALL be ignored.
REQ-036 start SHALL be ignored in RUN, RISE and FALL.
REQ-037 pos SHALL always satisfy MIN_Y<=pos<=GROUND_Y.
REQ-038 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-039 While rst=0, asynchronously: state=IDLE, pos=GROUND_Y, vel=0, airborne=0, anim_frame=0, anim counter=0, jump_pend=0, registered jump copy=0.
REQ-040 Reset asserted mid-jump SHALL return pos to GROUND_Y immediately, without waiting for a clk edge.
REQ-041 After release, the block SHALL stay in IDLE until a start pulse.

Verification
REQ-042 Full jump, defaults: start, then jump edge, then ticks -> pos 190,181,173,166,160,155,151,148,146,145 (FALL after tick 10), then 146,148,151,155,160,166,173,181,190,200; RUN on tick 20, airborne low from then on.
REQ-043 Buffered jump: jump edge at the 15th airborne tick -> landing at tick 20, then RISE on tick 21 with pos still 200, and pos=190 on tick 22; a second edge in air is dropped, giving exactly one extra jump.
REQ-044 Ceiling clamp, JUMP_V0=31 and GROUND_Y=60: jump -> pos reaches 28, never lower, on the tick that crosses it; state goes to FALL on that same tick.
REQ-045 Death and restart: game_over at the 5th airborne tick, holding pos=160 -> DEAD; pos stays 160 over 50 ticks and jump edges; start pulse -> pos=200, state=RUN.
REQ-046 Animation: 12 ticks in RUN -> anim_frame toggles after tick 6 and tick 12; it is held during a jump.
REQ-047 Async reset mid-FALL -> pos=200 and state=IDLE before the next clk edge; ticks after release give no change until start.

Source files
------------

// File: rtl/dino_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dino_jump_ctrl
// Description : Jump / run / death controller for the dino sprite. Tracks the
//               dino bottom-edge row with a simple ballistic model stepped by
//               a frame tick, buffers one jump request, and drives the leg
//               animation frame while running.
// Revision    : 1.0 - initial release
// ============================================================================
module dino_jump_ctrl #(
  parameter int unsigned GROUND_Y   = 200,
  parameter int unsigned MIN_Y      = 28,
  parameter int unsigned JUMP_V0    = 10,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned VMAX       = 15,
  parameter int unsigned ANIM_TICKS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       jump,
  input  logic       game_over,
  output logic [8:0] pos,
  output logic       airborne,
  output logic       anim_frame,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_RISE = 3'd2,
    ST_FALL = 3'd3,
    ST_DEAD = 3'd4
  } state_e;

  localparam int ACW = (ANIM_TICKS > 2) ? $clog2(ANIM_TICKS) : 1;

  // All motion arithmetic is done at 10 bits so nothing wraps before the clamp.
  localparam logic [9:0]     c_ground_y10 = 10'(GROUND_Y);
  localparam logic [9:0]     c_min_y10    = 10'(MIN_Y);
  localparam logic [9:0]     c_grav10     = 10'(GRAVITY);
  localparam logic [9:0]     c_vmax10     = 10'(VMAX);
  localparam logic [8:0]     c_ground_y9  = 9'(GROUND_Y);
  localparam logic [8:0]     c_min_y9     = 9'(MIN_Y);
  localparam logic [4:0]     c_grav5      = 5'(GRAVITY);
  localparam logic [4:0]     c_jump_v05   = 5'(JUMP_V0);
  localparam logic [ACW-1:0] c_anim_last  = ACW'(ANIM_TICKS - 1);
  localparam logic [ACW-1:0] c_anim_one   = ACW'(1);

  state_e         state_q, state_d;
  logic [8:0]     pos_q, pos_d;
  logic [4:0]     vel_q, vel_d;
  logic [ACW-1:0] cnt_q, cnt_d;
  logic           frame_q, frame_d;
  logic           pend_q, pend_d;
  logic           jump_q;
  logic           airborne_q, airborne_d;

  logic           w_edge;
  logic [9:0]     w_pos10;
  logic [9:0]     w_vel10;
  logic [9:0]     w_rise_pos;
  logic           w_rise_hit;
  logic [9:0]     w_vel_inc;
  logic [9:0]     w_fall_v;
  logic [9:0]     w_fall_pos;

  assign w_edge     = jump & ~jump_q;
  assign w_pos10    = {1'b0, pos_q};
  assign w_vel10    = {5'b0, vel_q};
  // A negative rise result shows up as bit 9 set; treat it as hitting the ceiling.
  assign w_rise_pos = w_pos10 - w_vel10;
  assign w_rise_hit = w_rise_pos[9] | (w_rise_pos <= c_min_y10);
  assign w_vel_inc  = w_vel10 + c_grav10;
  assign w_fall_v   = (w_vel_inc > c_vmax10) ? c_vmax10 : w_vel_inc;
  assign w_fall_pos = w_pos10 + w_fall_v;

  // Next-state, motion, jump buffer and animation decisions.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    pend_d  = pend_q;

    case (state_q)
      ST_IDLE, ST_DEAD: begin
        pend_d = 1'b0;
        if (start) begin
          state_d = ST_RUN;
          pos_d   = c_ground_y9;
          vel_d   = 5'd0;
          cnt_d   = '0;
          frame_d = 1'b0;
        end
      end

      ST_RUN, ST_RISE, ST_FALL: begin
        if (game_over) begin
          // Collision freezes everything visible; only the request is dropped.
          state_d = ST_DEAD;
          pend_d  = 1'b0;
        end else begin
          if (w_edge) begin
            pend_d = 1'b1;
          end
          if (tick) begin
            case (state_q)
              ST_RUN: begin
                if (pend_q || w_edge) begin
                  pend_d  = 1'b0;
                  vel_d   = c_jump_v05;
                  state_d = ST_RISE;
                end else if (cnt_q == c_anim_last) begin
                  cnt_d   = '0;
                  frame_d = ~frame_q;
                end else begin
                  cnt_d = cnt_q + c_anim_one;
                end
              end
              ST_RISE: begin
                pos_d = w_rise_hit ? c_min_y9 : w_rise_pos[8:0];
                if ((vel_q <= c_grav5) || w_rise_hit) begin
                  vel_d   = 5'd0;
                  state_d = ST_FALL;
                end else begin
                  vel_d = vel_q - c_grav5;
                end
              end
              default: begin
                if (w_fall_pos >= c_ground_y10) begin
                  pos_d   = c_ground_y9;
                  vel_d   = 5'd0;
                  state_d = ST_RUN;
                end else begin
                  pos_d = w_fall_pos[8:0];
                  vel_d = w_fall_v[4:0];
                end
              end
            endcase
          end
        end
      end

      default: begin
        // Unused codes recover to IDLE.
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase

    airborne_d = (state_d == ST_RISE) || (state_d == ST_FALL);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pos_q      <= c_ground_y9;
      vel_q      <= 5'd0;
      cnt_q      <= '0;
      frame_q    <= 1'b0;
      pend_q     <= 1'b0;
      jump_q     <= 1'b0;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      vel_q      <= vel_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      pend_q     <= pend_d;
      jump_q     <= jump;
      airborne_q <= airborne_d;
    end
  end

  assign pos        = pos_q;
  assign airborne   = airborne_q;
  assign anim_frame = frame_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_dino_jump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dino_jump_ctrl
// Description : Self-checking bench for dino_jump_ctrl: directed scenarios
//               plus randomized stimulus against a behavioural game model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dino_jump_ctrl;

  localparam int GY = 200;
  localparam int MY = 28;
  localparam int V0 = 10;
  localparam int G  = 1;
  localparam int VM = 15;
  localparam int AT = 6;

  logic       clk = 1'b0;
  logic       rst, tick, start, jump, game_over;
  logic [8:0] pos, pos2;
  logic       airborne, airborne2, anim_frame, anim_frame2;
  logic [2:0] state, state2;

  always #5 clk = ~clk;

  dino_jump_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .jump(jump),
    .game_over(game_over), .pos(pos), .airborne(airborne),
    .anim_frame(anim_frame), .state(state)
  );

  dino_jump_ctrl #(.GROUND_Y(60), .JUMP_V0(31)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .jump(jump),
    .game_over(game_over), .pos(pos2), .airborne(airborne2),
    .anim_frame(anim_frame2), .state(state2)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural game model (default parameters): 0 idle,1 run,2 rise,3 fall,4 dead
  int m_state, m_pos, m_vel, m_cnt, m_frame, m_pend, m_jprev;

  int full_seq [20] = '{190,181,173,166,160,155,151,148,146,145,
                        146,148,151,155,160,166,173,181,190,200};

  task automatic model_reset();
    m_state = 0; m_pos = GY; m_vel = 0; m_cnt = 0; m_frame = 0; m_pend = 0; m_jprev = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit j, input bit g);
    bit ej;
    int np, v;
    ej = j && (m_jprev == 0);
    m_jprev = j;
    if (m_state == 0 || m_state == 4) begin
      m_pend = 0;
      if (s) begin
        m_state = 1; m_pos = GY; m_vel = 0; m_cnt = 0; m_frame = 0;
      end
    end else if (g) begin
      m_state = 4; m_pend = 0;
    end else begin
      if (ej) m_pend = 1;
      if (t) begin
        if (m_state == 1) begin
          if (m_pend != 0) begin
            m_pend = 0; m_vel = V0; m_state = 2;
          end else if (m_cnt == AT - 1) begin
            m_cnt = 0; m_frame = 1 - m_frame;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else if (m_state == 2) begin
          np = m_pos - m_vel;
          if (m_vel <= G || np <= MY) begin
            m_vel = 0; m_state = 3;
          end else begin
            m_vel = m_vel - G;
          end
          m_pos = (np < MY) ? MY : np;
        end else begin
          v = (m_vel + G > VM) ? VM : m_vel + G;
          if (m_pos + v >= GY) begin
            m_pos = GY; m_vel = 0; m_state = 1;
          end else begin
            m_pos = m_pos + v; m_vel = v;
          end
        end
      end
    end
  endtask

  // Apply inputs at the falling edge, clock once, return at the next falling edge.
  task automatic drive(input bit t, input bit s, input bit j, input bit g);
    tick = t; start = s; jump = j; game_over = g;
    @(posedge clk);
    model_step(t, s, j, g);
    @(negedge clk);
  endtask

  task automatic restart();
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (pos !== 9'd200) begin failures++; $display("FAIL reset_pos got=%0d exp=200", pos); end
    checks++; if (airborne !== 1'b0) begin failures++; $display("FAIL reset_airborne got=%b exp=0", airborne); end
    checks++; if (anim_frame !== 1'b0) begin failures++; $display("FAIL reset_anim got=%b exp=0", anim_frame); end
    checks++; if (pos2 !== 9'd60) begin failures++; $display("FAIL reset_pos2 got=%0d exp=60", pos2); end
    rst = 1'b1;
    for (int k = 0; k < 6; k++) drive(1, 0, k[0], 0);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL idle_hold_state got=%0d exp=0", state); end
    checks++; if (pos !== 9'd200) begin failures++; $display("FAIL idle_hold_pos got=%0d exp=200", pos); end
  endtask

  task automatic test_full_jump();
    drive(0, 1, 0, 0);
    checks++; if (state !== 3'd1 || pos !== 9'd200) begin failures++; $display("FAIL start_run state=%0d pos=%0d exp state=1 pos=200", state, pos); end
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    checks++; if (state !== 3'd2 || pos !== 9'd200) begin failures++; $display("FAIL jump_take state=%0d pos=%0d exp state=2 pos=200", state, pos); end
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0);
      checks++; if (pos !== 9'(full_seq[i])) begin failures++; $display("FAIL full_jump_pos tick=%0d got=%0d exp=%0d", i + 1, pos, full_seq[i]); end
      if (i == 8) begin
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL full_jump_rise got=%0d exp=2", state); end
      end
      if (i == 9) begin
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL full_jump_fall got=%0d exp=3", state); end
      end
      if (i == 18) begin
        checks++; if (airborne !== 1'b1) begin failures++; $display("FAIL full_jump_air got=%b exp=1", airborne); end
      end
    end
    checks++; if (state !== 3'd1 || airborne !== 1'b0) begin failures++; $display("FAIL full_jump_land state=%0d air=%b exp state=1 air=0", state, airborne); end
  endtask

  task automatic test_ceiling();
    int minp;
    int n;
    restart();
    drive(0, 0, 1, 0);
    drive(1, 0, 1, 0);
    checks++; if (state2 !== 3'd2 || pos2 !== 9'd60) begin failures++; $display("FAIL ceil_take state=%0d pos=%0d exp state=2 pos=60", state2, pos2); end
    drive(1, 0, 0, 0);
    checks++; if (state2 !== 3'd2 || pos2 !== 9'd29) begin failures++; $display("FAIL ceil_step1 state=%0d pos=%0d exp state=2 pos=29", state2, pos2); end
    drive(1, 0, 0, 0);
    checks++; if (state2 !== 3'd3 || pos2 !== 9'd28) begin failures++; $display("FAIL ceil_clamp state=%0d pos=%0d exp state=3 pos=28", state2, pos2); end
    minp = 28;
    n = 0;
    while (state2 !== 3'd1 && n < 40) begin
      drive(1, 0, 0, 0);
      if (int'(pos2) < minp) minp = int'(pos2);
      n++;
    end
    checks++; if (n >= 40) begin failures++; $display("FAIL ceil_land_timeout state=%0d exp=1", state2); end
    checks++; if (minp < 28 || pos2 !== 9'd60) begin failures++; $display("FAIL ceil_bounds min=%0d pos=%0d exp min=28 pos=60", minp, pos2); end
  endtask

  task automatic test_buffered_jump();
    bit j;
    restart();
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      j = (k == 15) || (k == 16) || (k == 18);
      drive(1, 0, j, 0);
    end
    checks++; if (state !== 3'd1 || pos !== 9'd200) begin failures++; $display("FAIL buf_land state=%0d pos=%0d exp state=1 pos=200", state, pos); end
    drive(1, 0, 0, 0);
    checks++; if (state !== 3'd2 || pos !== 9'd200) begin failures++; $display("FAIL buf_take state=%0d pos=%0d exp state=2 pos=200", state, pos); end
    drive(1, 0, 0, 0);
    checks++; if (pos !== 9'd190) begin failures++; $display("FAIL buf_rise got=%0d exp=190", pos); end
    for (int k = 23; k <= 41; k++) drive(1, 0, 0, 0);
    checks++; if (state !== 3'd1 || pos !== 9'd200) begin failures++; $display("FAIL buf_land2 state=%0d pos=%0d exp state=1 pos=200", state, pos); end
    drive(1, 0, 0, 0);
    checks++; if (state !== 3'd1 || airborne !== 1'b0) begin failures++; $display("FAIL buf_single state=%0d air=%b exp state=1 air=0", state, airborne); end
  endtask

  task automatic test_animation();
    bit held;
    restart();
    checks++; if (anim_frame !== 1'b0) begin failures++; $display("FAIL anim_start got=%b exp=0", anim_frame); end
    for (int k = 1; k <= 18; k++) begin
      drive(1, 0, 0, 0);
      if (k == 5 || k == 12) begin
        checks++; if (anim_frame !== 1'b0) begin failures++; $display("FAIL anim_tick%0d got=%b exp=0", k, anim_frame); end
      end
      if (k == 6 || k == 11 || k == 18) begin
        checks++; if (anim_frame !== 1'b1) begin failures++; $display("FAIL anim_tick%0d got=%b exp=1", k, anim_frame); end
      end
    end
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    held = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 0, 0);
      if (anim_frame !== 1'b1) held = 1'b0;
    end
    checks++; if (held !== 1'b1) begin failures++; $display("FAIL anim_held got=0 exp=1"); end
    for (int k = 0; k < 6; k++) drive(1, 0, 0, 0);
    checks++; if (anim_frame !== 1'b0) begin failures++; $display("FAIL anim_resume got=%b exp=0", anim_frame); end
  endtask

  task automatic test_death_restart();
    int fexp;
    restart();
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(1, 0, 0, 0);
    checks++; if (pos !== 9'd160) begin failures++; $display("FAIL death_pre got=%0d exp=160", pos); end
    fexp = m_frame;
    drive(1, 0, 0, 1);
    checks++; if (state !== 3'd4 || pos !== 9'd160) begin failures++; $display("FAIL death_enter state=%0d pos=%0d exp state=4 pos=160", state, pos); end
    for (int k = 0; k < 50; k++) begin
      drive(1, 0, k[0], (k % 3) == 0);
      checks++; if (state !== 3'd4 || pos !== 9'd160 || anim_frame !== 1'(fexp)) begin
        failures++; $display("FAIL death_hold k=%0d state=%0d pos=%0d frame=%b exp state=4 pos=160 frame=%0d", k, state, pos, anim_frame, fexp);
      end
    end
    drive(0, 1, 0, 1);
    checks++; if (state !== 3'd1 || pos !== 9'd200 || anim_frame !== 1'b0) begin failures++; $display("FAIL death_restart state=%0d pos=%0d frame=%b exp 1/200/0", state, pos, anim_frame); end
    drive(0, 1, 0, 1);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL go_beats_start got=%0d exp=4", state); end
    drive(0, 1, 0, 0);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL dead_start got=%0d exp=1", state); end
  endtask

  task automatic test_async_reset();
    restart();
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    for (int k = 0; k < 13; k++) drive(1, 0, 0, 0);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL areset_pre got=%0d exp=3", state); end
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (pos !== 9'd200 || state !== 3'd0 || airborne !== 1'b0) begin failures++; $display("FAIL areset_now state=%0d pos=%0d air=%b exp 0/200/0", state, pos, airborne); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) drive(1, 0, k[0], 0);
    checks++; if (state !== 3'd0 || pos !== 9'd200) begin failures++; $display("FAIL areset_idle state=%0d pos=%0d exp 0/200", state, pos); end
  endtask

  task automatic test_random();
    bit t, s, g, jl;
    jl = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      t = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 19) == 0);
      g = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) jl = ~jl;
      drive(t, s, jl, g);
      checks++; if (state !== 3'(m_state)) begin failures++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", k, state, m_state); end
      checks++; if (pos !== 9'(m_pos)) begin failures++; $display("FAIL rand_pos cyc=%0d got=%0d exp=%0d", k, pos, m_pos); end
      checks++; if (airborne !== (m_state == 2 || m_state == 3)) begin failures++; $display("FAIL rand_air cyc=%0d got=%b exp=%0d", k, airborne, (m_state == 2 || m_state == 3)); end
      checks++; if (anim_frame !== 1'(m_frame)) begin failures++; $display("FAIL rand_anim cyc=%0d got=%b exp=%0d", k, anim_frame, m_frame); end
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; start = 1'b0; jump = 1'b0; game_over = 1'b0;
    model_reset();
    test_reset();
    test_full_jump();
    test_ceiling();
    test_buffered_jump();
    test_animation();
    test_death_restart();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
